// File: rtl/gtxe2_chnl_cpll_ctrl.sv
// CPLL bring-up sequencer for a GTXE2 channel: power-down, reset pulse, filtered
// lock wait with bounded retries, and relock on lock loss or reference-clock loss.
module gtxe2_chnl_cpll_ctrl #(
    parameter int unsigned PD_CYCLES    = 16,
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_FILTER  = 4,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cpll_lock,
    input  logic       refclk_lost,
    output logic       cpll_pd,
    output logic       cpll_reset,
    output logic       lock_en,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PWRDN  = 3'd1;
    localparam logic [2:0] S_RESET  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam int unsigned PH_MAX = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned FLT_W  = $clog2(LOCK_FILTER + 1);

    localparam logic [PH_W-1:0]  PD_LAST  = PH_W'(PD_CYCLES - 1);
    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    logic [2:0]       state_q, state_d, fsm_nxt_s;
    logic [PH_W-1:0]  ph_q, ph_d, ph_inc_s;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc_s;
    logic [FLT_W-1:0] flt_q, flt_d, flt_inc_s;
    logic [3:0]       retry_q, retry_d, retry_nxt_s;
    logic [1:0]       lock_sync_q, lost_sync_q;
    logic             lock_s, lost_s, changed_s;
    logic             cpll_pd_q, cpll_reset_q, lock_en_q, ready_q, fail_q;

    assign lock_s = lock_sync_q[1];
    assign lost_s = lost_sync_q[1];

    // Saturating increments so no counter can wrap whatever the parameters.
    assign ph_inc_s  = (ph_q  == {PH_W{1'b1}})  ? ph_q  : ph_q  + 1'b1;
    assign tmo_inc_s = (tmo_q == {TMO_W{1'b1}}) ? tmo_q : tmo_q + 1'b1;
    assign flt_inc_s = (flt_q == {FLT_W{1'b1}}) ? flt_q : flt_q + 1'b1;

    // Next-state selection; enable low overrides every other transition.
    always_comb begin
        fsm_nxt_s   = state_q;
        retry_nxt_s = retry_q;
        case (state_q)
            S_IDLE:   fsm_nxt_s = S_PWRDN;
            S_PWRDN:  fsm_nxt_s = (ph_q == PD_LAST) ? S_RESET : S_PWRDN;
            S_RESET: begin
                if (lost_s) begin
                    fsm_nxt_s = S_PWRDN;
                end else begin
                    fsm_nxt_s = (ph_q == RST_LAST) ? S_WAIT : S_RESET;
                end
            end
            S_WAIT: begin
                if (lost_s) begin
                    fsm_nxt_s = S_PWRDN;
                end else if (lock_s && (flt_q == FLT_LAST)) begin
                    fsm_nxt_s = S_LOCKED;
                end else if (tmo_q == TMO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        fsm_nxt_s   = S_RESET;
                        retry_nxt_s = retry_q + 4'd1;
                    end else begin
                        fsm_nxt_s = S_FAIL;
                    end
                end else begin
                    fsm_nxt_s = S_WAIT;
                end
            end
            S_LOCKED: begin
                if (lost_s) begin
                    fsm_nxt_s = S_PWRDN;
                end else begin
                    fsm_nxt_s = lock_s ? S_LOCKED : S_RESET;
                end
            end
            S_FAIL:   fsm_nxt_s = S_FAIL;
            default:  fsm_nxt_s = S_IDLE;
        endcase
    end

    // Counter and retry updates; every state change restarts the per-state counters.
    always_comb begin
        state_d   = enable ? fsm_nxt_s : S_IDLE;
        changed_s = (state_d != state_q);
        ph_d      = changed_s ? '0 : ph_inc_s;
        tmo_d     = (changed_s || (state_q != S_WAIT)) ? '0 : tmo_inc_s;
        flt_d     = (changed_s || (state_q != S_WAIT) || !lock_s) ? '0 : flt_inc_s;
        retry_d   = ((state_d == S_IDLE) || (state_d == S_LOCKED)) ? 4'd0 : retry_nxt_s;
    end

    // Two-flop synchronizers for the asynchronous PLL status inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= 2'b00;
            lost_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], cpll_lock};
            lost_sync_q <= {lost_sync_q[0], refclk_lost};
        end
    end

    // State, counters, and output flops; outputs track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ph_q         <= '0;
            tmo_q        <= '0;
            flt_q        <= '0;
            retry_q      <= 4'd0;
            cpll_pd_q    <= 1'b1;
            cpll_reset_q <= 1'b0;
            lock_en_q    <= 1'b0;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            tmo_q        <= tmo_d;
            flt_q        <= flt_d;
            retry_q      <= retry_d;
            cpll_pd_q    <= (state_d == S_IDLE) || (state_d == S_PWRDN) || (state_d == S_FAIL);
            cpll_reset_q <= (state_d == S_RESET);
            lock_en_q    <= (state_d == S_WAIT) || (state_d == S_LOCKED);
            ready_q      <= (state_d == S_LOCKED);
            fail_q       <= (state_d == S_FAIL);
        end
    end

    assign cpll_pd    = cpll_pd_q;
    assign cpll_reset = cpll_reset_q;
    assign lock_en    = lock_en_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;
    assign state      = state_q;

endmodule

// File: doc/gtxe2_chnl_cpll_ctrl.md
GTXE2_CHNL_CPLL_CTRL -- requirements
Module: gtxe2_chnl_cpll_ctrl

Interface
REQ-001 SHALL have parameter PD_CYCLES, default 16: cycles of power-down before reset, range 1..65535.
REQ-002 SHALL have parameter RST_CYCLES, default 8: cycles the CPLL reset is held, range 1..65535.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_LOCK per attempt, range 1..2^20-1.
REQ-004 SHALL have parameter LOCK_FILTER, default 4: consecutive synchronized lock-high cycles required to declare lock, range 1..255.
REQ-005 SHALL have parameter MAX_RETRY, default 3: relock retries after the first attempt before FAIL, range 0..15.
REQ-006 clk  in  1  single controller clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 enable  in  1  level request to bring up and hold the CPLL.
REQ-009 cpll_lock  in  1  CPLLLOCK from the channel PLL, asynchronous to clk.
REQ-010 refclk_lost  in  1  CPLLREFCLKLOST, asynchronous to clk.
REQ-011 cpll_pd  out  1  drives CPLLPD.
REQ-012 cpll_reset  out  1  drives CPLLRESET, active high.
REQ-013 lock_en  out  1  drives CPLLLOCKEN.
REQ-014 ready  out  1  CPLL locked and stable.
REQ-015 fail  out  1  retries exhausted.
REQ-016 retry_cnt  out  4  retries used in the current bring-up.
REQ-017 state  out  3  current state encoding.

Function
REQ-018 States and encodings: IDLE=0, PWRDN=1, RESET=2, WAIT_LOCK=3, LOCKED=4, FAIL=5; 6,7 unreachable, recover to IDLE next cycle.
REQ-019 cpll_lock and refclk_lost each pass through a 2-flop synchronizer; the FSM uses only the synchronized values (2-cycle latency).
REQ-020 All outputs are registered and decoded from the registered state: cpll_pd=1 in IDLE/PWRDN/FAIL; cpll_reset=1 in RESET only; lock_en=1 in WAIT_LOCK/LOCKED; ready=1 in LOCKED only; fail=1 in FAIL only.
REQ-021 enable=0 in any state -> IDLE on the next edge; priority over every other transition.
REQ-022 IDLE & enable=1 -> PWRDN; retry_cnt cleared to 0 in IDLE.
REQ-023 PWRDN lasts exactly PD_CYCLES cycles, then -> RESET.
REQ-024 RESET lasts exactly RST_CYCLES cycles, then -> WAIT_LOCK; lock filter and timeout counters cleared on entry.
REQ-025 WAIT_LOCK: filter counter increments while synchronized lock=1, clears to 0 when lock=0; reaching LOCK_FILTER -> LOCKED.
REQ-026 WAIT_LOCK: timeout counter increments each cycle; reaching LOCK_TIMEOUT without lock -> RESET with retry_cnt+1 if retry_cnt<MAX_RETRY, else -> FAIL with retry_cnt unchanged.
REQ-027 Lock-filter completion and timeout in the same cycle: lock wins (-> LOCKED).
REQ-028 Entry to LOCKED clears retry_cnt to 0.
REQ-029 LOCKED: synchronized lock=0 for one cycle -> RESET, retry_cnt unchanged (fresh relock sequence).
REQ-030 Synchronized refclk_lost=1 in RESET, WAIT_LOCK or LOCKED -> PWRDN, retry_cnt unchanged; priority below enable=0, above lock/timeout events.
REQ-031 FAIL is sticky while enable=1; exit only via enable=0 -> IDLE.
REQ-032 Counters saturate and never wrap; widths sized from parameters.

Reset
REQ-033 rst_n=0 forces state=IDLE, all counters and synchronizers 0, cpll_pd=1, cpll_reset=0, lock_en=0, ready=0, fail=0, retry_cnt=0, asynchronously; rst_n mid-sequence aborts with no further output pulses.
REQ-034 First transition out of IDLE occurs no earlier than the first edge after rst_n deasserts.

Verification
REQ-035 Defaults, enable=1 at cycle 0, cpll_lock=1 from start of WAIT_LOCK -> cpll_pd 1 for 16 PWRDN cycles, cpll_reset 1 for exactly 8 cycles, ready=1 at WAIT_LOCK entry + 2 sync + 4 filter cycles.
REQ-036 cpll_lock never asserts -> 4 WAIT_LOCK attempts of 4096 cycles, retry_cnt 0->1->2->3, then FAIL with fail=1, cpll_pd=1, until enable=0 gives IDLE.
REQ-037 cpll_lock toggling high 3 cycles/low 1 cycle in WAIT_LOCK -> never reaches LOCKED, timeout retry taken.
REQ-038 In LOCKED, cpll_lock low 1 cycle -> ready=0, 8-cycle cpll_reset pulse, relock, retry_cnt remains 0.
REQ-039 refclk_lost pulse (3 cycles) in LOCKED -> PWRDN then full 16+8 sequence, retry_cnt unchanged.
REQ-040 rst_n asserted mid-RESET and enable dropped mid-WAIT_LOCK -> immediate/next-edge IDLE outputs per REQ-033/REQ-021.
